// File: rtl/alu_pipe_ds_pkg.sv
// Shared types for the pipelined ALU: operation codes, flag bundle and
// the signed-overflow helpers used by the combinational core.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB_AB = 3'b001,
    ALU_SUB_BA = 3'b010,
    ALU_OR     = 3'b011,
    ALU_AND    = 3'b100,
    ALU_XOR    = 3'b101,
    ALU_XNOR   = 3'b110,
    ALU_ZERO   = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  // x+y overflows when operands agree in sign and the result does not
  function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
    return (sx == sy) && (sr != sx);
  endfunction

  // x-y overflows when operand signs differ and the result leaves x's sign
  function automatic logic sub_ovf(input logic sx, input logic sy, input logic sr);
    return (sx != sy) && (sr != sx);
  endfunction

endpackage

// File: rtl/alu_pipe_ds_if.sv
// Issue/writeback handshake bundle for alu_pipe_ds: valid/ready in, valid/ready out.
interface alu_pipe_ds_if #(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       oper;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, a, b, oper, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, a, b, oper, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );
endinterface

// File: rtl/alu_pipe_ds_core.sv
// Combinational ALU core: WIDTH+1-bit arithmetic on zero-extended operands,
// carry/borrow from the extra bit, signed overflow from operand/result signs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH:0] sum;
  logic           c;
  logic           v;

  always_comb begin
    sum = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        c   = sum[WIDTH];
        v   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      // the extra bit of a zero-extended difference is the borrow
      ALU_SUB_AB: begin
        sum = {1'b0, a} - {1'b0, b};
        c   = sum[WIDTH];
        v   = sub_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_SUB_BA: begin
        sum = {1'b0, b} - {1'b0, a};
        c   = sum[WIDTH];
        v   = sub_ovf(b[WIDTH-1], a[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_OR:   sum = {1'b0, a | b};
      ALU_AND:  sum = {1'b0, a & b};
      ALU_XOR:  sum = {1'b0, a ^ b};
      ALU_XNOR: sum = {1'b0, ~(a ^ b)};
      default:  sum = '0;
    endcase
  end

  assign result  = sum[WIDTH-1:0];
  assign flags.c = c;
  assign flags.v = v;
  assign flags.z = (result == '0);
  assign flags.n = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe_ds.sv
// Two-stage pipelined ALU: S1 holds operands, S2 holds result/flags.
// Full backpressure; in_ready depends only on stage state and out_ready.
module alu_pipe_ds
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_pipe_ds_if.slave    bus
);

  logic [2:1]       vld_pipe;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] s2_res;
  alu_flags_t       s2_flags;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;

  assign s2_adv  = vld_pipe[2] && bus.out_ready;
  assign s1_adv  = vld_pipe[1] && (!vld_pipe[2] || s2_adv);
  assign in_xfer = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !vld_pipe[1] || s1_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_res),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_xfer || (vld_pipe[1] && !s1_adv);
      vld_pipe[2] <= s1_adv  || (vld_pipe[2] && !s2_adv);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= ALU_ADD;
    end else if (in_xfer) begin
      s1_a  <= bus.a;
      s1_b  <= bus.b;
      s1_op <= alu_op_e'(bus.oper);
    end
  end

  // S2 only loads on S1 advance, so it holds stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s1_adv) begin
      s2_res   <= core_res;
      s2_flags <= core_flags;
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.result    = s2_res;
  assign bus.flag_c    = s2_flags.c;
  assign bus.flag_v    = s2_flags.v;
  assign bus.flag_z    = s2_flags.z;
  assign bus.flag_n    = s2_flags.n;

endmodule

// File: tb/tb_alu_pipe_ds.sv
// Bench for alu_pipe_ds at WIDTH 8, 64 and 13 against a signed/unsigned
// arithmetic reference model and in-order scoreboards.
module tb_alu_pipe_ds;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_pipe_ds_if #(.WIDTH(8))  i8 ();
  alu_pipe_ds_if #(.WIDTH(64)) i64 ();
  alu_pipe_ds_if #(.WIDTH(13)) i13 ();

  alu_pipe_ds #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  alu_pipe_ds #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64));
  alu_pipe_ds #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(i13));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [67:0] q8[$];
  logic [67:0] q64[$];
  logic [67:0] q13[$];
  int          got8, got64, got13, acc13;
  logic [3:0]  last_f64;
  logic [63:0] last_r64;
  logic        hold13;
  logic [12:0] held_r13;
  logic [3:0]  held_f13;

  // Result = true sum/difference reduced mod 2^w; borrow = unsigned compare;
  // overflow = signed value outside [-2^(w-1), 2^(w-1)-1]. Returns {r, c, v, z, n}.
  function automatic logic [67:0] ref_alu(input int w, input logic [63:0] a, b, input logic [2:0] op);
    logic signed [67:0] sa, sb, s, lim;
    logic [67:0] ua, ub, m, t;
    logic [63:0] r;
    logic c, v, ar;
    ua = {4'b0, a};
    ub = {4'b0, b};
    m  = (68'd1 << w) - 68'd1;
    sa = $signed(ua);
    sb = $signed(ub);
    if (a[w-1]) sa = sa - $signed(m) - 68'sd1;
    if (b[w-1]) sb = sb - $signed(m) - 68'sd1;
    lim = $signed(m >> 1) + 68'sd1;
    c = 1'b0; v = 1'b0; s = '0; ar = 1'b0; t = '0;
    case (op)
      3'd0: begin t = ua + ub; c = (ua + ub) > m; s = sa + sb; ar = 1'b1; end
      3'd1: begin t = ua - ub; c = ua < ub;       s = sa - sb; ar = 1'b1; end
      3'd2: begin t = ub - ua; c = ub < ua;       s = sb - sa; ar = 1'b1; end
      3'd3: t = ua | ub;
      3'd4: t = ua & ub;
      3'd5: t = ua ^ ub;
      3'd6: t = ~(ua ^ ub);
      default: t = '0;
    endcase
    r = t[63:0] & m[63:0];
    if (ar) v = (s >= lim) || (s < -lim);
    return {r, c, v, (r == 64'd0), r[w-1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s", tag);
  endtask

  task automatic step8(input logic iv, input logic [7:0] av, bv, input logic [2:0] op,
                       input logic ordy, output logic acc);
    logic [67:0] e;
    @(negedge clk);
    i8.in_valid = iv; i8.a = av; i8.b = bv; i8.oper = op; i8.out_ready = ordy;
    #1;
    acc = i8.in_valid && i8.in_ready;
    if (i8.out_valid && i8.out_ready) begin
      if (q8.size() == 0) fail_now("w8_spurious_output");
      else begin
        e = q8.pop_front();
        got8++;
        check("w8_result", 64'(i8.result), e[67:4]);
        check("w8_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'(e[3:0]));
      end
    end
    if (acc) q8.push_back(ref_alu(8, 64'(av), 64'(bv), op));
  endtask

  task automatic step64(input logic iv, input logic [63:0] av, bv, input logic [2:0] op, input logic ordy);
    logic [67:0] e;
    @(negedge clk);
    i64.in_valid = iv; i64.a = av; i64.b = bv; i64.oper = op; i64.out_ready = ordy;
    #1;
    if (i64.out_valid && i64.out_ready) begin
      if (q64.size() == 0) fail_now("w64_spurious_output");
      else begin
        e = q64.pop_front();
        got64++;
        last_r64 = i64.result;
        last_f64 = {i64.flag_c, i64.flag_v, i64.flag_z, i64.flag_n};
        check("w64_result", i64.result, e[67:4]);
        check("w64_flags", 64'(last_f64), 64'(e[3:0]));
      end
    end
    if (i64.in_valid && i64.in_ready) q64.push_back(ref_alu(64, av, bv, op));
  endtask

  task automatic step13(input logic iv, input logic [12:0] av, bv, input logic [2:0] op, input logic ordy);
    logic [67:0] e;
    int occ;
    @(negedge clk);
    i13.in_valid = iv; i13.a = av; i13.b = bv; i13.oper = op; i13.out_ready = ordy;
    #1;
    occ = q13.size();
    check("w13_in_ready", 64'(i13.in_ready), (occ < 2) ? 64'd1 : 64'(ordy));
    if (occ == 2) check("w13_full_out_valid", 64'(i13.out_valid), 64'd1);
    if (hold13) begin
      check("w13_hold_valid", 64'(i13.out_valid), 64'd1);
      check("w13_hold_result", 64'(i13.result), 64'(held_r13));
      check("w13_hold_flags", 64'({i13.flag_c, i13.flag_v, i13.flag_z, i13.flag_n}), 64'(held_f13));
    end
    hold13   = i13.out_valid && !i13.out_ready;
    held_r13 = i13.result;
    held_f13 = {i13.flag_c, i13.flag_v, i13.flag_z, i13.flag_n};
    if (i13.out_valid && i13.out_ready) begin
      if (q13.size() == 0) fail_now("w13_spurious_output");
      else begin
        e = q13.pop_front();
        got13++;
        check("w13_result", 64'(i13.result), e[67:4]);
        check("w13_flags", 64'(held_f13), 64'(e[3:0]));
      end
    end
    if (i13.in_valid && i13.in_ready) begin
      acc13++;
      q13.push_back(ref_alu(13, 64'(av), 64'(bv), op));
    end
  endtask

  initial begin
    logic        acc;
    int          idx, cyc, base;
    logic [7:0]  sa[4];
    logic [7:0]  sb[4];
    logic [2:0]  so[4];
    logic [63:0] pa, pb;

    checks = 0; errors = 0; got8 = 0; got64 = 0; got13 = 0; acc13 = 0;
    hold13 = 1'b0; held_r13 = '0; held_f13 = '0; last_f64 = '0; last_r64 = '0;
    rst_n = 1'b0;
    i8.in_valid = 0;  i8.a = 0;  i8.b = 0;  i8.oper = 0;  i8.out_ready = 0;
    i64.in_valid = 0; i64.a = 0; i64.b = 0; i64.oper = 0; i64.out_ready = 0;
    i13.in_valid = 0; i13.a = 0; i13.b = 0; i13.oper = 0; i13.out_ready = 0;
    repeat (2) @(negedge clk);

    check("rst_out_valid", 64'(i8.out_valid), 64'd0);
    check("rst_result", 64'(i8.result), 64'd0);
    check("rst_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'd0);
    check("rst_out_valid64", 64'(i64.out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(i8.in_ready), 64'd1);

    // 0xFF + 0x01: latency and carry-out/zero
    step8(1, 8'hFF, 8'h01, 3'd0, 1, acc);
    check("add_accepted", 64'(acc), 64'd1);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    check("add_not_yet_valid", 64'(i8.out_valid), 64'd0);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    check("add_valid", 64'(i8.out_valid), 64'd1);
    check("add_result", 64'(i8.result), 64'h00);
    check("add_flags_cvzn", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'b1010);

    // 0x80-0x01 overflows positive; 0x01-0x80 = 129 overflows too and borrows
    step8(1, 8'h80, 8'h01, 3'd1, 1, acc);
    step8(1, 8'h80, 8'h01, 3'd2, 1, acc);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    check("sub_ab_result", 64'(i8.result), 64'h7F);
    check("sub_ab_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'b0100);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    check("sub_ba_result", 64'(i8.result), 64'h81);
    check("sub_ba_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'b1101);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);

    // stall: out_ready low for 5 cycles while offering 4 ops
    sa = '{8'h12, 8'h50, 8'h0F, 8'hAA};
    sb = '{8'h34, 8'h20, 8'hF0, 8'h55};
    so = '{3'd0, 3'd1, 3'd3, 3'd5};
    base = got8;
    idx = 0;
    repeat (5) begin
      step8(1, sa[idx], sb[idx], so[idx], 0, acc);
      if (acc) idx++;
    end
    check("stall_accepted", 64'(idx), 64'd2);
    check("stall_in_ready", 64'(i8.in_ready), 64'd0);
    check("stall_out_valid", 64'(i8.out_valid), 64'd1);
    check("stall_result", 64'(i8.result), 64'h46);
    step8(1, sa[idx], sb[idx], so[idx], 0, acc);
    check("stall_result_hold", 64'(i8.result), 64'h46);
    check("stall_hold_no_accept", 64'(acc), 64'd0);
    cyc = 0;
    while ((idx < 4 || q8.size() != 0) && cyc < 50) begin
      if (idx < 4) begin
        step8(1, sa[idx], sb[idx], so[idx], 1, acc);
        if (acc) idx++;
      end else step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
      cyc++;
    end
    if (cyc >= 50) fail_now("stall_drain_timeout");
    check("stall_delivered", 64'(got8 - base), 64'd4);

    // reset with both stages full
    step8(1, 8'h11, 8'h22, 3'd0, 0, acc);
    step8(1, 8'h33, 8'h44, 3'd4, 0, acc);
    step8(0, 8'h00, 8'h00, 3'd0, 0, acc);
    check("full_before_rst_valid", 64'(i8.out_valid), 64'd1);
    check("full_before_rst_ready", 64'(i8.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(i8.out_valid), 64'd0);
    check("midrst_result", 64'(i8.result), 64'd0);
    check("midrst_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'd0);
    check("midrst_in_ready", 64'(i8.in_ready), 64'd1);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step8(1, 8'h03, 8'h05, 3'd1, 1, acc);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    step8(0, 8'h00, 8'h00, 3'd0, 1, acc);
    check("after_rst_result", 64'(i8.result), 64'hFE);
    check("after_rst_flags", 64'({i8.flag_c, i8.flag_v, i8.flag_z, i8.flag_n}), 64'b1001);

    // 64-bit back-to-back logic ops: one result per cycle
    pa = 64'hF0F0_F0F0_F0F0_F0F0;
    pb = 64'hFF00_FF00_FF00_FF00;
    base = got64;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 5) step64(1, pa, pb, 3'(k + 2), 1);
      else        step64(0, 64'd0, 64'd0, 3'd0, 1);
      check("w64_stream_count", 64'(got64 - base), (k >= 3) ? 64'(k - 2) : 64'd0);
    end
    check("w64_zero_result", last_r64, 64'd0);
    check("w64_zero_flags", 64'(last_f64), 64'b0010);

    // WIDTH=13 random traffic with random backpressure
    cyc = 0;
    while ((acc13 < 10000 || q13.size() != 0) && cyc < 60000) begin
      step13((acc13 < 10000) && ($urandom_range(0, 3) != 0),
             13'($urandom), 13'($urandom), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0);
      cyc++;
    end
    if (cyc >= 60000) fail_now("w13_timeout");
    check("w13_delivered", 64'(got13), 64'd10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
